// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and the PLL + video reset domain.
// The sequencer uses the master modport; the PLL/video side (or a bench) uses slave.
interface pll_lock_sequencer_if;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       error;
  logic       lock_lost;
  logic [2:0] retry_cnt;
  logic [7:0] lost_cnt;

  modport master (
    input  restart,
    input  pll_locked,
    output pll_rst,
    output sys_rst_n,
    output ready,
    output error,
    output lock_lost,
    output retry_cnt,
    output lost_cnt
  );

  modport slave (
    output restart,
    output pll_locked,
    input  pll_rst,
    input  sys_rst_n,
    input  ready,
    input  error,
    input  lock_lost,
    input  retry_cnt,
    input  lost_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Pixel-clock PLL bring-up: pulses the PLL reset, waits for and qualifies lock, then
// releases the video reset; retries on timeout/lock loss and parks in FAULT when out of budget.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 50000,
  parameter int LOCK_STABLE     = 1024,
  parameter int MAX_RETRIES     = 7,
  parameter int CNT_W           = 16
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_error;
  logic             r_lock_lost;
  logic [2:0]       r_retry_cnt;
  logic [7:0]       r_lost_cnt;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_retry_nxt;
  logic [7:0]       w_lost_nxt;
  logic             w_lock_lost_nxt;
  logic             w_lock_s;

  assign w_lock_s = r_sync2;

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned; a missing default here would infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_retry_nxt     = r_retry_cnt;
    w_lost_nxt      = r_lost_cnt;
    w_lock_lost_nxt = 1'b0;

    if (bus.restart) begin
      // Restart outranks everything, including a simultaneous lock drop in RUN.
      w_state_nxt = S_RESET_PLL;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end
        end

        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = S_STABILIZE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_cnt_nxt = '0;
            if (r_retry_cnt == RETRY_MAX) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_state_nxt = S_RESET_PLL;
              w_retry_nxt = r_retry_cnt + 3'd1;
            end
          end
        end

        S_STABILIZE: begin
          // A lock glitch restarts the timeout window but does not spend a retry.
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end
        end

        S_RUN: begin
          w_cnt_nxt = '0;
          if (!w_lock_s) begin
            w_state_nxt     = S_RESET_PLL;
            w_lock_lost_nxt = 1'b1;
            w_retry_nxt     = '0;
            if (r_lost_cnt != 8'hFF) begin
              w_lost_nxt = r_lost_cnt + 8'd1;
            end
          end
        end

        S_FAULT: begin
          w_cnt_nxt = '0;
        end

        default: begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry_cnt <= '0;
      r_lost_cnt  <= '0;
    end else begin
      r_sync1     <= bus.pll_locked;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_lost_cnt  <= w_lost_nxt;
      r_lock_lost <= w_lock_lost_nxt;
      // Outputs decode the next state so they move on the same edge as the state.
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
      r_sys_rst_n <= (w_state_nxt == S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_error     <= (w_state_nxt == S_FAULT);
    end
  end

  assign bus.pll_rst   = r_pll_rst;
  assign bus.sys_rst_n = r_sys_rst_n;
  assign bus.ready     = r_ready;
  assign bus.error     = r_error;
  assign bus.lock_lost = r_lock_lost;
  assign bus.retry_cnt = r_retry_cnt;
  assign bus.lost_cnt  = r_lost_cnt;

endmodule
